// File: rtl/pipe_addsub_pkg.sv
// Shared types and helpers for the pipelined add/subtract unit.
// Flag generation lives here so the top only wires registered MSBs into it.
package pipe_addsub_pkg;

    typedef struct packed {
        logic cout;
        logic ovf;
        logic zero;
        logic neg;
    } addsub_flags_t;

    // Legal geometry: at least one stage, no more stages than bits, equal chunks.
    function automatic logic geometry_ok(input int width, input int stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

    // ovf and zero are qualified by valid so an empty output slot reports no condition.
    function automatic addsub_flags_t calc_flags(
        input logic vld,
        input logic carry,
        input logic a_msb,
        input logic bp_msb,
        input logic y_msb,
        input logic y_is_zero
    );
        addsub_flags_t f;
        f.cout = carry;
        f.ovf  = vld & (a_msb == bp_msb) & (y_msb != a_msb);
        f.zero = vld & y_is_zero;
        f.neg  = y_msb;
        return f;
    endfunction

endpackage

// File: rtl/addsub_chunk_stage.sv
// One carry-chunk pipeline stage: resolves chunk IDX of the sum from the incoming
// carry and forwards operands, partial sum and carry under a common hold enable.
module addsub_chunk_stage #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4,
    parameter int IDX    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             vld_d,
    input  logic [WIDTH-1:0] a_d,
    input  logic [WIDTH-1:0] bp_d,
    input  logic [WIDTH-1:0] sum_d,
    input  logic             carry_d,
    output logic             vld_q,
    output logic [WIDTH-1:0] a_q,
    output logic [WIDTH-1:0] bp_q,
    output logic [WIDTH-1:0] sum_q,
    output logic             carry_q
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int LSB   = IDX * CHUNK;

    logic [CHUNK:0]   chunk_sum;
    logic [WIDTH-1:0] sum_nxt;

    always_comb begin
        chunk_sum = {1'b0, a_d[LSB +: CHUNK]} + {1'b0, bp_d[LSB +: CHUNK]}
                  + {{CHUNK{1'b0}}, carry_d};
        sum_nxt = sum_d;
        sum_nxt[LSB +: CHUNK] = chunk_sum[CHUNK-1:0];
    end

    // Stage register: sum and carry are reset so the unit output reads zero after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q   <= 1'b0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else if (advance) begin
            vld_q   <= vld_d;
            sum_q   <= sum_nxt;
            carry_q <= chunk_sum[CHUNK];
        end
    end

    always_ff @(posedge clk) begin
        if (advance) begin
            a_q  <= a_d;
            bp_q <= bp_d;
        end
    end

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined add/subtract unit: the carry chain is split into STAGES chunks, one
// resolved per clock, with valid/ready handshakes and NZCV-style flags.
module pipe_addsub
    import pipe_addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic             neg
);
    if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
        $error("pipe_addsub: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
    end

    logic                    advance;
    logic [STAGES:0]         vld_p;
    logic [STAGES:0]         carry_p;
    logic [STAGES:0][WIDTH-1:0] a_p;
    logic [STAGES:0][WIDTH-1:0] bp_p;
    logic [STAGES:0][WIDTH-1:0] sum_p;
    addsub_flags_t           flags;
    logic                    unused_ops;

    // The whole pipe moves or holds as one; bubbles are kept, never collapsed.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage 0 inputs: subtraction is A + ~B + 1, so cin is ignored there.
    assign vld_p[0]   = in_valid;
    assign a_p[0]     = a;
    assign bp_p[0]    = sub ? ~b : b;
    assign sum_p[0]   = '0;
    assign carry_p[0] = sub ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        addsub_chunk_stage #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES),
            .IDX    (k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .advance (advance),
            .vld_d   (vld_p[k]),
            .a_d     (a_p[k]),
            .bp_d    (bp_p[k]),
            .sum_d   (sum_p[k]),
            .carry_d (carry_p[k]),
            .vld_q   (vld_p[k+1]),
            .a_q     (a_p[k+1]),
            .bp_q    (bp_p[k+1]),
            .sum_q   (sum_p[k+1]),
            .carry_q (carry_p[k+1])
        );
    end

    // Output stage: result and flags come straight from the last stage registers.
    assign out_valid = vld_p[STAGES];
    assign y         = sum_p[STAGES];
    assign flags     = calc_flags(vld_p[STAGES], carry_p[STAGES],
                                  a_p[STAGES][WIDTH-1], bp_p[STAGES][WIDTH-1],
                                  sum_p[STAGES][WIDTH-1], sum_p[STAGES] == '0);
    assign cout      = flags.cout;
    assign ovf       = flags.ovf;
    assign zero      = flags.zero;
    assign neg       = flags.neg;

    // Only the operand MSBs matter after the last chunk has been resolved.
    assign unused_ops = ^{a_p[STAGES], bp_p[STAGES]};

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed-vector bench for pipe_addsub: three configurations (32/4, 64/8, 8/1)
// share one stimulus path and one in-order scoreboard.
`timescale 1ns/1ps
module tb_pipe_addsub;

    typedef struct {
        logic [63:0] y;
        logic        cout, ovf, zero, neg;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [63:0] a, b;
        logic        sub, cin;
        logic [63:0] y;
        logic        cout, ovf, zero, neg;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid_d;
    logic        out_ready;
    logic [63:0] a_d, b_d;
    logic        sub_d, cin_d;
    logic [1:0]  sel;
    logic [2:0]  ivs, ir, ov, co, of, zr, ng;
    logic [31:0] y0;
    logic [63:0] y1;
    logic [7:0]  y2;
    logic        rdy, ovs;
    logic [63:0] ys;
    logic [3:0]  fs;

    int   w, lat;
    int   cyc = 0;
    int   n_vec = 0, n_err = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    logic mon_en, lat_chk;
    bit   done_tx;
    vec_t t32[$], t64[$], t8[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign ivs = in_valid_d ? (3'b001 << sel) : 3'b000;

    pipe_addsub #(.WIDTH(32), .STAGES(4)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(ivs[0]), .in_ready(ir[0]),
        .a(a_d[31:0]), .b(b_d[31:0]), .sub(sub_d), .cin(cin_d),
        .out_valid(ov[0]), .out_ready(out_ready), .y(y0),
        .cout(co[0]), .ovf(of[0]), .zero(zr[0]), .neg(ng[0]));

    pipe_addsub #(.WIDTH(64), .STAGES(8)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(ivs[1]), .in_ready(ir[1]),
        .a(a_d), .b(b_d), .sub(sub_d), .cin(cin_d),
        .out_valid(ov[1]), .out_ready(out_ready), .y(y1),
        .cout(co[1]), .ovf(of[1]), .zero(zr[1]), .neg(ng[1]));

    pipe_addsub #(.WIDTH(8), .STAGES(1)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(ivs[2]), .in_ready(ir[2]),
        .a(a_d[7:0]), .b(b_d[7:0]), .sub(sub_d), .cin(cin_d),
        .out_valid(ov[2]), .out_ready(out_ready), .y(y2),
        .cout(co[2]), .ovf(of[2]), .zero(zr[2]), .neg(ng[2]));

    always_comb begin
        rdy = ir[sel];
        ovs = ov[sel];
        fs  = {co[sel], of[sel], zr[sel], ng[sel]};
        case (sel)
            2'd1:    ys = y1;
            2'd2:    ys = {56'd0, y2};
            default: ys = {32'd0, y0};
        endcase
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Signed/unsigned reference computed from whole-word arithmetic.
    function automatic exp_t model(input int wd, input logic [63:0] ra, input logic [63:0] rb,
                                   input logic rs, input logic rc);
        exp_t e;
        logic [64:0] m, ua, ub, ur;
        logic signed [66:0] sa, sb, sr, smax, smin;
        m  = (65'd1 << wd) - 65'd1;
        ua = {1'b0, ra} & m;
        ub = {1'b0, rb} & m;
        sa = $signed({2'b00, ua});
        if (ua[wd-1]) sa = sa - (67'sd1 <<< wd);
        sb = $signed({2'b00, ub});
        if (ub[wd-1]) sb = sb - (67'sd1 <<< wd);
        if (rs) begin
            ur     = (ua - ub) & m;
            sr     = sa - sb;
            e.cout = (ua >= ub);
        end else begin
            ur     = ua + ub + {64'd0, rc};
            sr     = sa + sb + $signed({66'd0, rc});
            e.cout = ur[wd];
            ur     = ur & m;
        end
        smax   = (67'sd1 <<< (wd - 1)) - 67'sd1;
        smin   = -(67'sd1 <<< (wd - 1));
        e.ovf  = (sr > smax) || (sr < smin);
        e.y    = ur[63:0];
        e.zero = (ur == 65'd0);
        e.neg  = ur[wd-1];
        e.cyc  = 0;
        return e;
    endfunction

    function automatic vec_t vec(input logic [63:0] va, input logic [63:0] vb, input logic vs,
                                 input logic vc, input logic [63:0] vy, input logic vco,
                                 input logic vov, input logic vz, input logic vn);
        vec_t v;
        v.a = va; v.b = vb; v.sub = vs; v.cin = vc;
        v.y = vy; v.cout = vco; v.ovf = vov; v.zero = vz; v.neg = vn;
        return v;
    endfunction

    function automatic exp_t from_vec(input vec_t v);
        exp_t e;
        e.y = v.y; e.cout = v.cout; e.ovf = v.ovf; e.zero = v.zero; e.neg = v.neg;
        e.cyc = 0;
        return e;
    endfunction

    // Output monitor: compares every output transfer with the head of the scoreboard.
    always @(negedge clk) begin
        #2;
        if (mon_en && ovs && out_ready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_output: got y=%h, want no output", ys);
            end else begin
                mon_e = exp_q.pop_front();
                check("y", ys, mon_e.y);
                check("flags_cvzn", {60'd0, fs},
                      {60'd0, mon_e.cout, mon_e.ovf, mon_e.zero, mon_e.neg});
                if (lat_chk) check("latency", 64'(cyc - mon_e.cyc), 64'(lat));
            end
        end
    end

    // Called at a falling edge; returns at a falling edge with in_valid low.
    task automatic send(input logic [63:0] ta, input logic [63:0] tbv, input logic ts,
                        input logic tc, input exp_t e);
        int n;
        a_d = ta; b_d = tbv; sub_d = ts; cin_d = tc; in_valid_d = 1'b1;
        #1;
        n = 0;
        while (!rdy && n < 200) begin
            @(negedge clk); #1;
            n++;
        end
        if (!rdy) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: got in_ready=0, want 1 within 200 cycles");
            in_valid_d = 1'b0;
            return;
        end
        e.cyc = cyc;
        @(posedge clk); #1;
        exp_q.push_back(e);
        @(negedge clk);
        in_valid_d = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("pending_ops", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic use_dut(input logic [1:0] s);
        sel = s;
        case (s)
            2'd1:    begin w = 64; lat = 8; end
            2'd2:    begin w = 8;  lat = 1; end
            default: begin w = 32; lat = 4; end
        endcase
    endtask

    task automatic run_table(input vec_t t[$]);
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        foreach (t[i]) begin
            send(t[i].a, t[i].b, t[i].sub, t[i].cin, from_vec(t[i]));
            drain();
        end
    endtask

    function automatic logic [63:0] rand_op();
        logic [63:0] r;
        r = {$urandom, $urandom};
        case ($urandom_range(0, 3))
            0:       r = ~64'd0 - 64'($urandom_range(0, 3));
            1:       r = 64'($urandom_range(0, 3));
            default: ;
        endcase
        return r;
    endfunction

    task automatic run_stream(input int n);
        logic [63:0] ra, rb;
        logic rs, rc;
        out_ready = 1'b1;
        lat_chk   = 1'b1;
        for (int i = 0; i < n; i++) begin
            ra = rand_op(); rb = rand_op();
            rs = 1'($urandom_range(0, 1)); rc = 1'($urandom_range(0, 1));
            send(ra, rb, rs, rc, model(w, ra, rb, rs, rc));
        end
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before 500us");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] held_y, ra, rb;
        logic [3:0]  held_f;
        logic        seen, rs, rc;

        t32.push_back(vec(64'h5, 64'h3, 1'b0, 1'b0, 64'h8, 1'b0, 1'b0, 1'b0, 1'b0));
        t32.push_back(vec(64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0));
        t32.push_back(vec(64'h7FFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1));
        t32.push_back(vec(64'h5, 64'h7, 1'b1, 1'b0, 64'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1));
        t32.push_back(vec(64'h7, 64'h7, 1'b1, 1'b1, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0));
        t32.push_back(vec(64'h0000_FFFF, 64'h0, 1'b0, 1'b1, 64'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0));
        t32.push_back(vec(64'h8000_0000, 64'h1, 1'b1, 1'b0, 64'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0));

        t64.push_back(vec(64'h5, 64'h3, 1'b0, 1'b0, 64'h8, 1'b0, 1'b0, 1'b0, 1'b0));
        t64.push_back(vec(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0));
        t64.push_back(vec(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000,
                          1'b0, 1'b1, 1'b0, 1'b1));
        t64.push_back(vec(64'h5, 64'h7, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1));
        t64.push_back(vec(64'h7, 64'h7, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0));
        t64.push_back(vec(64'h0000_0000_FFFF_FFFF, 64'h0, 1'b0, 1'b1, 64'h0000_0001_0000_0000,
                          1'b0, 1'b0, 1'b0, 1'b0));

        t8.push_back(vec(64'h05, 64'h03, 1'b0, 1'b0, 64'h08, 1'b0, 1'b0, 1'b0, 1'b0));
        t8.push_back(vec(64'hFF, 64'h01, 1'b0, 1'b0, 64'h00, 1'b1, 1'b0, 1'b1, 1'b0));
        t8.push_back(vec(64'h7F, 64'h01, 1'b0, 1'b0, 64'h80, 1'b0, 1'b1, 1'b0, 1'b1));
        t8.push_back(vec(64'h05, 64'h07, 1'b1, 1'b0, 64'hFE, 1'b0, 1'b0, 1'b0, 1'b1));
        t8.push_back(vec(64'h07, 64'h07, 1'b1, 1'b0, 64'h00, 1'b1, 1'b0, 1'b1, 1'b0));
        t8.push_back(vec(64'h0F, 64'h00, 1'b0, 1'b1, 64'h10, 1'b0, 1'b0, 1'b0, 1'b0));

        rst_n = 1'b0; in_valid_d = 1'b0; out_ready = 1'b1;
        a_d = '0; b_d = '0; sub_d = 1'b0; cin_d = 1'b0;
        mon_en = 1'b1; lat_chk = 1'b0;
        use_dut(2'd0);

        // Reset state of every configuration.
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            use_dut(2'(s));
            #1;
            check("reset_out_valid", {63'd0, ovs}, 64'd0);
            check("reset_y", ys, 64'd0);
            check("reset_flags", {60'd0, fs}, 64'd0);
        end
        use_dut(2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", {63'd0, rdy}, 64'd1);
        @(negedge clk);

        // 32/4: directed vectors and a back-to-back stream.
        run_table(t32);
        run_stream(10);

        // Backpressure: fill the pipe with the consumer stalled.
        lat_chk = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ra = rand_op(); rb = rand_op(); rs = 1'($urandom_range(0, 1)); rc = 1'b1;
            send(ra, rb, rs, rc, model(32, ra, rb, rs, rc));
        end
        #1;
        check("stall_out_valid", {63'd0, ovs}, 64'd1);
        check("stall_in_ready", {63'd0, rdy}, 64'd0);
        held_y = ys;
        held_f = fs;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            check("stall_y_stable", ys, held_y);
            check("stall_flags_stable", {60'd0, fs}, {60'd0, held_f});
            check("stall_in_ready", {63'd0, rdy}, 64'd0);
        end
        out_ready = 1'b1;
        drain();

        // Random in_valid gaps against random consumer stalls.
        done_tx = 1'b0;
        fork
            begin
                logic [63:0] fa, fb;
                logic fsub, fc;
                for (int i = 0; i < 20; i++) begin
                    fa = rand_op(); fb = rand_op();
                    fsub = 1'($urandom_range(0, 1)); fc = 1'($urandom_range(0, 1));
                    send(fa, fb, fsub, fc, model(32, fa, fb, fsub, fc));
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
                done_tx = 1'b1;
            end
            begin
                int n;
                n = 0;
                while (!done_tx && n < 2000) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 1) != 0);
                    n++;
                end
                out_ready = 1'b1;
            end
        join
        drain();

        // Asynchronous reset with three operations in flight.
        @(negedge clk);
        send(64'h1234_5678, 64'h1111_1111, 1'b0, 1'b0, model(32, 64'h1234_5678, 64'h1111_1111, 1'b0, 1'b0));
        send(64'h0F0F_0F0F, 64'h0101_0101, 1'b1, 1'b0, model(32, 64'h0F0F_0F0F, 64'h0101_0101, 1'b1, 1'b0));
        send(64'hDEAD_BEEF, 64'h1, 1'b0, 1'b1, model(32, 64'hDEAD_BEEF, 64'h1, 1'b0, 1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", {63'd0, ovs}, 64'd0);
        check("async_rst_y", ys, 64'd0);
        check("async_rst_flags", {60'd0, fs}, 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (ovs) seen = 1'b1;
        end
        check("no_valid_after_reset", {63'd0, seen}, 64'd0);
        @(negedge clk);
        send(64'h5, 64'h3, 1'b0, 1'b0, from_vec(t32[0]));
        drain();

        // 64/8 and 8/1 configurations.
        use_dut(2'd1);
        @(negedge clk);
        run_table(t64);
        run_stream(10);

        use_dut(2'd2);
        @(negedge clk);
        run_table(t8);
        run_stream(10);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
